// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write arbiter: per-requester FIFOs, round-robin pop,
// registered write port and a combinational pending-write scoreboard mask.
module regfile_write_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [4:0]            a_addr,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [4:0]            b_addr,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  write_enable,
  output logic [4:0]            write_addr,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic [31:0]           pending_mask,
  output logic                  busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 5 + DATA_WIDTH;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  // Index 0 is requester A, index 1 is requester B.
  logic [ENT_W-1:0] mem [2][FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr [2];
  logic [PTR_W-1:0] wr_ptr [2];
  logic [CNT_W-1:0] cnt [2];
  logic [ENT_W-1:0] in_ent [2];
  logic [ENT_W-1:0] head [2];
  logic [1:0]       in_valid;
  logic [1:0]       rdy;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       nonempty;
  logic             last_grant_b;
  logic [ENT_W-1:0] pop_ent;
  logic [4:0]       pop_addr;
  logic [DATA_WIDTH-1:0] pop_data;

  assign in_valid  = {b_valid, a_valid};
  assign in_ent[0] = {a_addr, a_data};
  assign in_ent[1] = {b_addr, b_data};

  // Ready looks only at the registered count, so a full queue never accepts even while popping.
  always_comb begin
    for (int r = 0; r < 2; r++) begin
      nonempty[r] = (cnt[r] != '0);
      rdy[r]      = reset && (cnt[r] < DEPTH_C);
      push[r]     = in_valid[r] && rdy[r];
      head[r]     = mem[r][rd_ptr[r]];
    end
  end

  assign a_ready = rdy[0];
  assign b_ready = rdy[1];

  always_comb begin
    pop = 2'b00;
    if (nonempty[0] && (!nonempty[1] || last_grant_b)) pop[0] = 1'b1;
    else if (nonempty[1])                              pop[1] = 1'b1;
  end

  assign pop_ent  = pop[1] ? head[1] : head[0];
  assign pop_addr = pop_ent[ENT_W-1 -: 5];
  assign pop_data = pop_ent[DATA_WIDTH-1:0];

  // Queue storage carries data only and is qualified by the counts.
  always_ff @(posedge clk) begin
    for (int r = 0; r < 2; r++) begin
      if (push[r]) mem[r][wr_ptr[r]] <= in_ent[r];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < 2; r++) begin
        rd_ptr[r] <= '0;
        wr_ptr[r] <= '0;
        cnt[r]    <= '0;
      end
      last_grant_b <= 1'b1;
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
    end else begin
      for (int r = 0; r < 2; r++) begin
        if (push[r]) wr_ptr[r] <= wr_ptr[r] + PTR_W'(1);
        if (pop[r])  rd_ptr[r] <= rd_ptr[r] + PTR_W'(1);
        cnt[r] <= cnt[r] + CNT_W'(push[r]) - CNT_W'(pop[r]);
      end
      // x31 is hardwired zero: the entry drains but never strobes the register file.
      write_enable <= (|pop) && (pop_addr != 5'd31);
      if (|pop) begin
        last_grant_b <= pop[1];
        write_addr   <= pop_addr;
        write_data   <= pop_data;
      end
    end
  end

  always_comb begin
    logic [PTR_W-1:0] offset;
    logic [4:0]       ent_addr;
    pending_mask = '0;
    offset       = '0;
    ent_addr     = '0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        offset   = PTR_W'(i) - rd_ptr[r];
        ent_addr = mem[r][i][ENT_W-1 -: 5];
        if ({1'b0, offset} < cnt[r]) pending_mask[ent_addr] = 1'b1;
      end
    end
    if (write_enable) pending_mask[write_addr] = 1'b1;
    pending_mask[31] = 1'b0;
  end

  assign busy = (|nonempty) || write_enable;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: cycle-exact latency, arbitration order,
// backpressure, x31 suppression and mid-operation reset.
module tb_regfile_write_arbiter;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          a_valid, b_valid;
  logic          a_ready, b_ready;
  logic [4:0]    a_addr, b_addr;
  logic [DW-1:0] a_data, b_data;
  logic          write_enable;
  logic [4:0]    write_addr;
  logic [DW-1:0] write_data;
  logic [31:0]   pending_mask;
  logic          busy;

  int vectors = 0;
  int miscompares = 0;
  logic [4+DW:0] wq [$];
  int stall_a, stall_b;

  regfile_write_arbiter #(.FIFO_DEPTH(2), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .pending_mask(pending_mask), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (write_enable === 1'b1) wq.push_back({write_addr, write_data});

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic drive_stream(input bit is_b, output int stall_at);
    int   idx = 0;
    int   cyc = 0;
    logic rdy;
    stall_at = -1;
    while (idx < 4 && cyc < 40) begin
      if (is_b) begin
        b_valid = 1'b1; b_addr = 5'(16 + idx); b_data = DW'(32'hB00 + idx);
      end else begin
        a_valid = 1'b1; a_addr = 5'(8 + idx);  a_data = DW'(32'hA00 + idx);
      end
      @(negedge clk);
      rdy = is_b ? b_ready : a_ready;
      if (!rdy && stall_at < 0) stall_at = idx;
      step();
      if (rdy) idx++;
      cyc++;
    end
    if (is_b) b_valid = 1'b0; else a_valid = 1'b0;
    check_vec(is_b ? "stream_b_done" : "stream_a_done", 64'(idx), 64'd4);
  endtask

  initial begin
    logic [63:0] exp_ent;
    int cyc;
    idle_inputs();

    // Reset state
    reset = 1'b0;
    step();
    @(negedge clk);
    check_vec("rst_a_ready", 64'(a_ready), 64'd0);
    check_vec("rst_b_ready", 64'(b_ready), 64'd0);
    step();
    reset = 1'b1;
    @(negedge clk);
    check_vec("rel_a_ready", 64'(a_ready), 64'd1);
    check_vec("rel_b_ready", 64'(b_ready), 64'd1);
    check_vec("rel_we", 64'(write_enable), 64'd0);
    check_vec("rel_waddr", 64'(write_addr), 64'd0);
    check_vec("rel_wdata", write_data, 64'd0);
    check_vec("rel_mask", 64'(pending_mask), 64'd0);
    check_vec("rel_busy", 64'(busy), 64'd0);

    // Single A write x5 = 0x1234
    step();
    a_valid = 1'b1; a_addr = 5'd5; a_data = 64'h1234;
    @(negedge clk);
    check_vec("t1_a_ready", 64'(a_ready), 64'd1);
    step();
    idle_inputs();
    @(negedge clk);
    check_vec("t1_we_k", 64'(write_enable), 64'd0);
    check_vec("t1_mask_k", 64'(pending_mask), 64'h20);
    check_vec("t1_busy_k", 64'(busy), 64'd1);
    step();
    @(negedge clk);
    check_vec("t1_we_k1", 64'(write_enable), 64'd1);
    check_vec("t1_waddr", 64'(write_addr), 64'd5);
    check_vec("t1_wdata", write_data, 64'h1234);
    check_vec("t1_mask_k1", 64'(pending_mask), 64'h20);
    step();
    @(negedge clk);
    check_vec("t1_we_k2", 64'(write_enable), 64'd0);
    check_vec("t1_mask_k2", 64'(pending_mask), 64'd0);
    check_vec("t1_busy_k2", 64'(busy), 64'd0);
    check_vec("t1_waddr_hold", 64'(write_addr), 64'd5);

    // Simultaneous A x1 / B x2 after reset: A first
    do_reset();
    a_valid = 1'b1; a_addr = 5'd1; a_data = 64'hA;
    b_valid = 1'b1; b_addr = 5'd2; b_data = 64'hB;
    step();
    idle_inputs();
    @(negedge clk);
    check_vec("t2_we0", 64'(write_enable), 64'd0);
    check_vec("t2_mask0", 64'(pending_mask), 64'h6);
    step();
    @(negedge clk);
    check_vec("t2_we1", 64'(write_enable), 64'd1);
    check_vec("t2_addr1", 64'(write_addr), 64'd1);
    check_vec("t2_data1", write_data, 64'hA);
    check_vec("t2_mask1", 64'(pending_mask), 64'h6);
    step();
    @(negedge clk);
    check_vec("t2_we2", 64'(write_enable), 64'd1);
    check_vec("t2_addr2", 64'(write_addr), 64'd2);
    check_vec("t2_data2", write_data, 64'hB);
    step();
    @(negedge clk);
    check_vec("t2_we3", 64'(write_enable), 64'd0);
    check_vec("t2_busy3", 64'(busy), 64'd0);

    // Dual continuous streams: alternation, B backpressure after 2 accepts, pointer wrap
    do_reset();
    wq.delete();
    fork
      drive_stream(1'b0, stall_a);
      drive_stream(1'b1, stall_b);
    join
    cyc = 0;
    @(negedge clk);
    while (busy !== 1'b0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check_vec("t3_drained", 64'(busy), 64'd0);
    check_vec("t3_b_stall_idx", 64'(stall_b), 64'd2);
    check_vec("t3_count", 64'(wq.size()), 64'd8);
    for (int j = 0; j < wq.size() && j < 8; j++) begin
      if (j % 2 == 0) exp_ent = {27'd0, 5'(8 + j / 2), 32'hA00 + 32'(j / 2)};
      else            exp_ent = {27'd0, 5'(16 + j / 2), 32'hB00 + 32'(j / 2)};
      check_vec($sformatf("t3_write%0d", j), {27'd0, wq[j][4+DW:DW], wq[j][31:0]}, exp_ent);
    end

    // Write to x31 is drained silently
    do_reset();
    wq.delete();
    a_valid = 1'b1; a_addr = 5'd31; a_data = 64'hFFFF;
    @(negedge clk);
    check_vec("t4_a_ready", 64'(a_ready), 64'd1);
    step();
    idle_inputs();
    @(negedge clk);
    check_vec("t4_mask_q", 64'(pending_mask), 64'd0);
    check_vec("t4_busy_q", 64'(busy), 64'd1);
    step();
    @(negedge clk);
    check_vec("t4_we_pop", 64'(write_enable), 64'd0);
    check_vec("t4_mask_pop", 64'(pending_mask), 64'd0);
    step();
    @(negedge clk);
    check_vec("t4_busy_end", 64'(busy), 64'd0);
    check_vec("t4_no_writes", 64'(wq.size()), 64'd0);

    // Mid-operation reset discards queued writes
    do_reset();
    a_valid = 1'b1; a_addr = 5'd3; a_data = 64'h3;
    b_valid = 1'b1; b_addr = 5'd6; b_data = 64'h6;
    step();
    a_addr = 5'd4; a_data = 64'h4;
    b_valid = 1'b0;
    step();
    idle_inputs();
    @(negedge clk);
    check_vec("t5_we_pre", 64'(write_enable), 64'd1);
    check_vec("t5_waddr_pre", 64'(write_addr), 64'd3);
    check_vec("t5_mask_pre", 64'(pending_mask), 64'h58);
    reset = 1'b0;
    step();
    reset = 1'b1;
    @(negedge clk);
    check_vec("t5_we_post", 64'(write_enable), 64'd0);
    check_vec("t5_busy_post", 64'(busy), 64'd0);
    check_vec("t5_mask_post", 64'(pending_mask), 64'd0);
    check_vec("t5_a_ready_post", 64'(a_ready), 64'd1);
    check_vec("t5_b_ready_post", 64'(b_ready), 64'd1);
    wq.delete();
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
    end
    check_vec("t5_no_writes", 64'(wq.size()), 64'd0);
    check_vec("t5_busy_end", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, per-requester queue depth (power of two, >=2).
REQ-002 SHALL have parameter DATA_WIDTH, default 64, write data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset is synchronous and active-low (reset=0 clears state at the next clk edge).
REQ-005 SHALL have ports a_valid/b_valid  input  1  requester A (ALU writeback) / B (load return) write request.
REQ-006 SHALL have ports a_ready/b_ready  output  1  queue can accept the request this cycle.
REQ-007 SHALL have ports a_addr/b_addr  input  5  destination register index.
REQ-008 SHALL have ports a_data/b_data  input  DATA_WIDTH  value to write.
REQ-009 SHALL have port write_enable  output  1  registered write strobe to register file.
REQ-010 SHALL have port write_addr  output  5  registered register-file write address.
REQ-011 SHALL have port write_data  output  DATA_WIDTH  registered register-file write data.
REQ-012 SHALL have port pending_mask  output  32  bit r set while any write to xr is queued or presented.
REQ-013 SHALL have port busy  output  1  any queue non-empty or write_enable high.

Function
REQ-014 SHALL transfer a request when valid and ready are both high at a clk edge; data/addr captured into that requester's FIFO.
REQ-015 SHALL drive x_ready = (FIFO count < FIFO_DEPTH), from registered count only; no same-cycle pass-through when full, even if popping.
REQ-016 SHALL pop at most one entry total per cycle, from a non-empty FIFO head.
REQ-017 SHALL arbitrate round-robin: one head valid -> it wins; both valid -> winner is requester not granted last; last_grant updates only on a pop.
REQ-018 SHALL register popped entry into write_enable/write_addr/write_data at the pop edge; write_enable high exactly one cycle per popped entry (register file commits at following edge).
REQ-019 SHALL give latency: request accepted at edge k into empty FIFO, no contention -> popped at edge k+1, write_enable high during cycle k+1..k+2.
REQ-020 SHALL hold write_enable=0 when no pop occurs; write_addr/write_data hold last values.
REQ-021 SHALL pop entries addressed to x31 normally but drive write_enable=0 for them (x31 hardwired zero).
REQ-022 SHALL preserve per-requester FIFO order; cross-requester order to same register follows grant order.
REQ-023 SHALL compute pending_mask combinationally as OR of decoded addresses of all valid FIFO entries plus write_addr when write_enable=1; bit 31 always 0.
REQ-024 SHALL support simultaneous push and pop on same FIFO when not full: count unchanged, order preserved.
REQ-025 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH without loss or duplication.

Reset
REQ-026 SHALL, when reset=0 at a clk edge: clear both FIFOs (count 0), write_enable=0, write_addr=0, write_data=0, last_grant=B (A wins first tie).
REQ-027 SHALL ignore valid inputs while reset=0; a_ready/b_ready read 0 during reset cycles, 1 on first cycle after release.
REQ-028 SHALL discard in-flight queued writes when reset asserts mid-operation; no write_enable pulse follows.
REQ-029 SHALL drive pending_mask=0 and busy=0 in the cycle after reset.

Verification
REQ-030 SHALL pass: single A write x5=0x1234 at edge k -> write_enable=1, write_addr=5, write_data=0x1234 in cycle k+1 only; pending_mask[5]=1 cycles k..k+1.
REQ-031 SHALL pass: A(x1=0xA) and B(x2=0xB) accepted same edge after reset -> x1 written first, x2 next cycle; continuous dual streams alternate A,B,A,B.
REQ-032 SHALL pass: B held valid 4 cycles while A monopolises nothing, FIFO_DEPTH=2, pops blocked by steady A contention -> b_ready drops to 0 after 2 accepts; no entry lost, all 4 eventually written in order.
REQ-033 SHALL pass: A writes x31=0xFFFF -> a_ready handshake completes, write_enable stays 0, pending_mask[31]=0.
REQ-034 SHALL pass: 3 entries queued, reset=0 for one edge -> no write_enable afterwards, busy=0, pending_mask=0, readies 1 after release.
